// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: two requester byte handshakes plus the shared LCD bus and grant status.
interface lcd_bus_arbiter_if;
  logic       a_valid, a_rs, a_last, a_ready;
  logic [7:0] a_dat;
  logic       b_valid, b_rs, b_last, b_ready;
  logic [7:0] b_dat;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_dat;
  logic [1:0] owner;
  logic       busy;
  modport slave (
    input  a_valid, a_rs, a_dat, a_last, b_valid, b_rs, b_dat, b_last,
    output a_ready, b_ready, lcd_rs, lcd_rw, lcd_en, lcd_dat, owner, busy
  );
  modport master (
    output a_valid, a_rs, a_dat, a_last, b_valid, b_rs, b_dat, b_last,
    input  a_ready, b_ready, lcd_rs, lcd_rw, lcd_en, lcd_dat, owner, busy
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin arbiter serialising two byte streams onto a write-only LCD bus.
module lcd_bus_arbiter #(
  parameter int CLK_DIV   = 16,
  parameter int LONG_WAIT = 1600
) (
  input logic clk,
  input logic rst,
  lcd_bus_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, WAIT} state_t;
  localparam logic [15:0] DIV_LOAD  = 16'(CLK_DIV - 1);
  localparam logic [15:0] WAIT_LOAD = 16'(LONG_WAIT - 1);
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  owner, owner_n, grant;
  logic        rr_b, rr_n, last_q, last_n, rs_q, rs_n;
  logic [7:0]  dat_q, dat_n;
  logic        sel_valid, accept, long_cmd;
  // an idle bus grants and accepts in the same cycle, so grant is resolved combinationally
  assign grant = owner != 2'b00 ? owner :
                 (bus.a_valid && (!bus.b_valid || !rr_b)) ? 2'b01 :
                 bus.b_valid ? 2'b10 : 2'b00;
  assign sel_valid = grant[0] ? bus.a_valid : (grant[1] & bus.b_valid);
  assign accept    = state == IDLE && sel_valid && !rst;
  assign long_cmd  = LONG_WAIT > 0 && !rs_q && (dat_q == 8'h01 || dat_q == 8'h02);
  assign bus.a_ready = accept & grant[0];
  assign bus.b_ready = accept & grant[1];
  assign bus.lcd_en  = state == EN_HI;
  assign bus.lcd_rw  = 1'b0;
  assign bus.lcd_rs  = rs_q;
  assign bus.lcd_dat = dat_q;
  assign bus.owner   = owner;
  assign bus.busy    = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= 2'b00;
      rr_b   <= 1'b0;
      last_q <= 1'b0;
      rs_q   <= 1'b0;
      dat_q  <= 8'h00;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      owner  <= owner_n;
      rr_b   <= rr_n;
      last_q <= last_n;
      rs_q   <= rs_n;
      dat_q  <= dat_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    owner_n = owner;
    rr_n    = rr_b;
    last_n  = last_q;
    rs_n    = rs_q;
    dat_n   = dat_q;
    case (state)
      IDLE: if (accept) begin
        state_n = SETUP;
        cnt_n   = DIV_LOAD;
        owner_n = grant;
        last_n  = grant[0] ? bus.a_last : bus.b_last;
        rs_n    = grant[0] ? bus.a_rs : bus.b_rs;
        dat_n   = grant[0] ? bus.a_dat : bus.b_dat;
      end
      SETUP: begin
        state_n = cnt == 16'd0 ? EN_HI : SETUP;
        cnt_n   = cnt == 16'd0 ? DIV_LOAD : cnt - 16'd1;
      end
      EN_HI: begin
        state_n = cnt == 16'd0 ? EN_LO : EN_HI;
        cnt_n   = cnt == 16'd0 ? DIV_LOAD : cnt - 16'd1;
      end
      EN_LO: begin
        state_n = cnt != 16'd0 ? EN_LO : long_cmd ? WAIT : IDLE;
        cnt_n   = cnt != 16'd0 ? cnt - 16'd1 : long_cmd ? WAIT_LOAD : 16'd0;
      end
      WAIT: begin
        state_n = cnt == 16'd0 ? IDLE : WAIT;
        cnt_n   = cnt == 16'd0 ? 16'd0 : cnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
    // releasing the grant points round-robin at the other requester
    if (state != IDLE && state_n == IDLE && last_q) begin
      owner_n = 2'b00;
      rr_n    = owner[0];
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: table-driven transfers, handwritten arbitration/reset sequences, random run vs timeline model.
module tb_lcd_bus_arbiter;
  localparam int D = 4, W = 100;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  lcd_bus_arbiter_if bus();
  lcd_bus_arbiter #(.CLK_DIV(D), .LONG_WAIT(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  typedef struct { bit req; bit rs; logic [7:0] dat; int busy_cyc; } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    bus.a_valid = 0; bus.a_rs = 0; bus.a_dat = 0; bus.a_last = 0;
    bus.b_valid = 0; bus.b_rs = 0; bus.b_dat = 0; bus.b_last = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_in();
    bus.a_valid = 1;
    bus.b_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_en", bus.lcd_en, 0);
    chk("rst_rs", bus.lcd_rs, 0);
    chk("rst_dat", bus.lcd_dat, 0);
    chk("rst_rw", bus.lcd_rw, 0);
    chk("rst_ready", {bus.a_ready, bus.b_ready}, 0);
    clear_in();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.busy, 0);
  endtask

  task automatic send_one(input bit req, input bit rs, input logic [7:0] dat, input int busy_exp, input string tag);
    int n = 0, en_n = 0, first_en = -1, bad = 0;
    @(negedge clk);
    if (req) begin bus.b_valid = 1; bus.b_rs = rs; bus.b_dat = dat; bus.b_last = 1; end
    else     begin bus.a_valid = 1; bus.a_rs = rs; bus.a_dat = dat; bus.a_last = 1; end
    #1;
    chk({tag, "_ready"}, {bus.b_ready, bus.a_ready}, req ? 2'b10 : 2'b01);
    @(negedge clk);
    clear_in();
    bus.a_rs = ~rs; bus.a_dat = ~dat; bus.b_rs = ~rs; bus.b_dat = ~dat;
    while (bus.busy && n < 500) begin
      if (bus.lcd_en) begin
        en_n++;
        if (first_en < 0) first_en = n;
      end
      if (bus.lcd_rs !== rs || bus.lcd_dat !== dat) bad++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, busy_exp);
    chk({tag, "_en_width"}, en_n, D);
    chk({tag, "_en_start"}, first_en, D);
    chk({tag, "_bus_stable"}, bad, 0);
    chk({tag, "_owner_released"}, bus.owner, 0);
    chk({tag, "_dat_held"}, {bus.lcd_rs, bus.lcd_dat}, {rs, dat});
    clear_in();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, acount, bfirst;
    int at[3];
    vt[0] = '{0, 1, 8'h41, 3*D};
    vt[1] = '{0, 0, 8'h01, 3*D + W};
    vt[2] = '{1, 0, 8'h02, 3*D + W};
    vt[3] = '{0, 0, 8'h30, 3*D};
    vt[4] = '{1, 1, 8'h01, 3*D};
    vt[5] = '{1, 1, 8'h02, 3*D};
    vt[6] = '{0, 0, 8'h03, 3*D};
    clear_in();
    do_reset();
    for (int i = 0; i < 7; i++) send_one(vt[i].req, vt[i].rs, vt[i].dat, vt[i].busy_cyc, $sformatf("vec%0d", i));

    // both requesting from reset: A, then B, then A again
    do_reset();
    @(negedge clk);
    bus.a_valid = 1; bus.a_rs = 1; bus.a_dat = 8'h11; bus.a_last = 1;
    bus.b_valid = 1; bus.b_rs = 1; bus.b_dat = 8'h22; bus.b_last = 1;
    #1;
    chk("rr1_a_first", {bus.b_ready, bus.a_ready}, 2'b01);
    @(negedge clk);
    bus.a_valid = 0;
    #1;
    n = 1;
    while (!bus.b_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rr1_b_gap", n, 3*D + 1);
    chk("rr1_owner_free", bus.owner, 0);
    @(negedge clk);
    bus.b_valid = 0;
    wait_idle("rr1_idle");
    bus.a_valid = 1;
    bus.b_valid = 1;
    #1;
    chk("rr2_a_first", {bus.b_ready, bus.a_ready}, 2'b01);
    @(negedge clk);
    clear_in();
    wait_idle("rr2_idle");

    // A streams three bytes while B waits
    do_reset();
    acount = 0;
    bfirst = -1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      bus.a_valid = acount < 3; bus.a_rs = 1; bus.a_dat = 8'(8'h60 + acount); bus.a_last = acount == 2;
      bus.b_valid = 1; bus.b_rs = 1; bus.b_dat = 8'h77; bus.b_last = 1;
      #1;
      if (bus.a_ready && acount < 3) begin at[acount] = k; acount++; end
      if (bus.b_ready && bfirst < 0) bfirst = k;
    end
    clear_in();
    chk("stream_count", acount, 3);
    chk("stream_t1", at[1], 3*D + 1);
    chk("stream_t2", at[2], 2*(3*D + 1));
    chk("stream_b_after", bfirst, 3*(3*D + 1));
    wait_idle("stream_idle");

    // reset in the middle of EN_HI
    do_reset();
    @(negedge clk);
    bus.a_valid = 1; bus.a_rs = 1; bus.a_dat = 8'h55; bus.a_last = 1;
    @(negedge clk);
    clear_in();
    repeat (5) @(negedge clk);
    chk("mid_en_high", bus.lcd_en, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_en", bus.lcd_en, 0);
    chk("mid_rst_owner", bus.owner, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", {bus.a_ready, bus.b_ready}, 0);
    @(negedge clk);
    rst = 0;
    send_one(0, 0, 8'h38, 3*D, "post_rst");

    // random traffic against a timeline model
    do_reset();
    begin
      int t_acc = -100, end_c = -1, eff;
      logic [1:0] m_own = 0;
      bit m_ptr_b = 0, m_last = 0, m_rs = 0, idle, acc, lng;
      logic [7:0] m_dat = 0;
      for (int k = 0; k < 4000; k++) begin
        @(negedge clk);
        bus.a_valid = ($urandom % 3) != 0;
        bus.a_rs = $urandom;
        bus.a_dat = ($urandom % 8 == 0) ? 8'($urandom % 3) : 8'($urandom);
        bus.a_last = ($urandom % 3) == 0;
        bus.b_valid = ($urandom % 3) != 0;
        bus.b_rs = $urandom;
        bus.b_dat = ($urandom % 8 == 0) ? 8'($urandom % 3) : 8'($urandom);
        bus.b_last = ($urandom % 3) == 0;
        #1;
        if (k == end_c + 1 && m_last) begin
          m_ptr_b = m_own[0];
          m_own = 0;
          m_last = 0;
        end
        idle = k > end_c;
        chk("rnd_owner", bus.owner, m_own);
        chk("rnd_busy", bus.busy, !idle);
        chk("rnd_en", bus.lcd_en, k >= t_acc + D + 1 && k <= t_acc + 2*D);
        chk("rnd_lcd", {bus.lcd_rs, bus.lcd_dat}, {m_rs, m_dat});
        eff = m_own != 0 ? int'(m_own) : (bus.a_valid && (!bus.b_valid || !m_ptr_b)) ? 1 : bus.b_valid ? 2 : 0;
        acc = idle && ((eff == 1 && bus.a_valid) || (eff == 2 && bus.b_valid));
        chk("rnd_ready", {bus.b_ready, bus.a_ready}, {acc && eff == 2, acc && eff == 1});
        if (acc) begin
          t_acc = k;
          m_own = 2'(eff);
          m_rs = eff == 1 ? bus.a_rs : bus.b_rs;
          m_dat = eff == 1 ? bus.a_dat : bus.b_dat;
          m_last = eff == 1 ? bus.a_last : bus.b_last;
          lng = !m_rs && (m_dat == 8'h01 || m_dat == 8'h02);
          end_c = k + 3*D + (lng ? W : 0);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 16: clock cycles per bus phase (setup, enable-high, enable-low); legal range 2..65535.
REQ-002 Parameter LONG_WAIT, default 1600: extra idle cycles after a CLEAR (0x01) or HOME (0x02) command; legal range 0..65535.
REQ-003 clk  in  1  single system clock; all logic on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 a_valid  in  1  requester A offers a byte.
REQ-006 a_rs  in  1  A byte type: 0 = command, 1 = data.
REQ-007 a_dat  in  8  A byte value.
REQ-008 a_last  in  1  A byte ends A's packet and releases the grant.
REQ-009 a_ready  out  1  one-cycle accept strobe to A.
REQ-010 b_valid, b_rs, b_dat[7:0], b_last  in; b_ready  out: identical to the A signals, for requester B.
REQ-011 lcd_rs  out  1  LCD register select.
REQ-012 lcd_rw  out  1  LCD read/write; tied 0 (write only).
REQ-013 lcd_en  out  1  LCD enable strobe.
REQ-014 lcd_dat  out  8  LCD data bus.
REQ-015 owner  out  2  one-hot grant: 01 = A, 10 = B, 00 = none.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, SETUP, EN_HI, EN_LO, WAIT. A 16-bit phase counter counts CLK_DIV-1 down to 0 in SETUP, EN_HI and EN_LO, and LONG_WAIT-1 down to 0 in WAIT.
REQ-018 IDLE with owner=00: if only one requester is valid, grant it; if both are valid, grant the requester not granted last (round-robin); the pointer after reset favours A.
REQ-019 IDLE with owner set and that owner valid: assert its ready for exactly one cycle, latch rs/dat onto lcd_rs/lcd_dat, latch last, go to SETUP.
REQ-020 A grant and byte acceptance in the same IDLE cycle: ready is asserted in the cycle the grant is taken, giving zero bubble.
REQ-021 The non-owner's ready stays 0; its valid is ignored until the grant is released.
REQ-022 SETUP: lcd_en=0 for CLK_DIV cycles, then EN_HI: lcd_en=1 for CLK_DIV cycles, then EN_LO: lcd_en=0 for CLK_DIV cycles.
REQ-023 lcd_rs and lcd_dat stay stable from SETUP entry until the next byte is accepted.
REQ-024 End of EN_LO: if the latched byte is rs=0 with dat 0x01 or 0x02 and LONG_WAIT>0, go to WAIT; otherwise go to IDLE.
REQ-025 End of WAIT: go to IDLE.
REQ-026 Grant release: when returning to IDLE with the latched last=1, owner becomes 00 in that transition and the round-robin pointer records the released requester.
REQ-027 An owner that is not valid in IDLE keeps the grant; there is no timeout.
REQ-028 Byte period: a non-long byte takes exactly 3*CLK_DIV+1 cycles from one ready pulse to the next ready pulse of the same owner streaming back-to-back.
REQ-029 Input changes on valid/rs/dat after acceptance have no effect on the byte in flight.

Reset
REQ-030 While rst=1: state=IDLE, owner=00, round-robin pointer favours A, counter=0, lcd_en=0, lcd_rs=0, lcd_dat=0x00, a_ready=b_ready=0, busy=0, lcd_rw=0.
REQ-031 Reset asserted mid-transfer: lcd_en drops to 0 asynchronously, the byte in flight is abandoned, and no ready pulse is issued for it.

Verification (CLK_DIV=4, LONG_WAIT=100)
REQ-032 A sends data 0x41 with last=1 -> a_ready pulses once; lcd_en is high for exactly 4 cycles starting 4 cycles after acceptance; lcd_rs=1, lcd_dat=0x41; owner returns to 00 after 13 cycles.
REQ-033 A and B both valid from reset, each sending 1 byte with last=1 -> A is served first, then B; repeating the test with both valid again -> A is served first (pointer favours A after B's release).
REQ-034 A streams 3 bytes (last on the 3rd) while B is valid throughout -> all 3 A bytes are accepted at 13-cycle spacing before b_ready is ever asserted.
REQ-035 A sends command 0x01 -> after EN_LO, busy stays high for 100 extra cycles; next accept occurs 112+1 cycles after the first; command 0x30 -> no WAIT.
REQ-036 rst pulsed during EN_HI -> lcd_en=0 immediately, owner=00, busy=0; a fresh A byte afterwards is transferred normally.
